// File: rtl/heq_pkg.sv
// Shared types and default sizing for the histogram-equalisation frame controller.
package heq_pkg;

   localparam int unsigned DefDataWidth   = 8;
   localparam int unsigned DefFramePixels = 640 * 480;

   typedef enum logic [2:0] {
      INIT_CLR = 3'd0,
      IDLE     = 3'd1,
      ACCUM    = 3'd2,
      SCAN     = 3'd3,
      CLEAR    = 3'd4,
      DONE     = 3'd5
   } heq_state_e;

endpackage

// File: rtl/heq_cdf_accum.sv
// Running CDF over the histogram read-back stream plus first-nonzero (cdf-min) capture.
module heq_cdf_accum
   import heq_pkg::*;
#(
   parameter int unsigned FramePixels = DefFramePixels,
   parameter int unsigned PixCntWidth = $clog2(FramePixels + 1)
) (
   input  logic                   i_clk,
   input  logic                   i_reset_n,
   input  logic                   i_scan_start,
   input  logic                   i_bin_rd,
   input  logic [PixCntWidth-1:0] i_bin_data,
   output logic                   o_cdf_valid,
   output logic [PixCntWidth-1:0] o_cdf,
   output logic [PixCntWidth-1:0] o_cdf_min
);

   localparam int unsigned          SumWidth = PixCntWidth + 1;
   localparam logic [SumWidth-1:0]  SumMax   = SumWidth'(FramePixels);

   logic [PixCntWidth-1:0] acc_q;
   logic [SumWidth-1:0]    sum_wide;
   logic [PixCntWidth-1:0] sum_sat;

   // Add the returning bin to the running sum, saturating at a full frame.
   always_comb begin
      sum_wide = {1'b0, acc_q} + {1'b0, i_bin_data};
      sum_sat  = (sum_wide > SumMax) ? PixCntWidth'(FramePixels) : sum_wide[PixCntWidth-1:0];
   end

   // RAM data lands one cycle after the strobe, so the CDF is formed as it arrives.
   assign o_cdf = o_cdf_valid ? sum_sat : '0;

   // Valid delay, running sum and cdf-min capture; all restart on SCAN entry.
   always_ff @(posedge i_clk or negedge i_reset_n) begin
      if (!i_reset_n) begin
         o_cdf_valid <= 1'b0;
         acc_q       <= '0;
         o_cdf_min   <= '0;
      end else begin
         o_cdf_valid <= i_bin_rd;
         if (i_scan_start) begin
            acc_q     <= '0;
            o_cdf_min <= '0;
         end else if (o_cdf_valid) begin
            acc_q <= sum_sat;
            if ((o_cdf_min == '0) && (sum_sat != '0)) begin
               o_cdf_min <= sum_sat;
            end
         end
      end
   end

endmodule

// File: rtl/heq_frame_ctrl.sv
// Frame controller for histogram equalisation: gates pixel accumulation, scans the
// histogram RAM into a running CDF, then clears it. Optional macro
// HEQ_FRAME_CTRL_FRAME_CNT_EN adds a 16-bit completed-frame counter output.
module heq_frame_ctrl
   import heq_pkg::*;
#(
   parameter int unsigned DataWidth   = DefDataWidth,
   parameter int unsigned FramePixels = DefFramePixels,
   parameter int unsigned PixCntWidth = $clog2(FramePixels + 1)
) (
   input  logic                   i_clk,
   input  logic                   i_reset_n,
   input  logic                   i_frame_start,
   input  logic                   i_pixel_valid,
   output logic                   o_hist_inc_en,
   output logic [DataWidth-1:0]   o_bin_addr,
   output logic                   o_bin_rd,
   input  logic [PixCntWidth-1:0] i_bin_data,
   output logic                   o_bin_clr,
   output logic                   o_cdf_valid,
   output logic [PixCntWidth-1:0] o_cdf,
   output logic [PixCntWidth-1:0] o_cdf_min,
   output logic                   o_busy,
   output logic                   o_frame_done,
`ifdef HEQ_FRAME_CTRL_FRAME_CNT_EN
   output logic                   o_overrun,
   output logic [15:0]            o_frame_count
`else
   output logic                   o_overrun
`endif
);

   localparam logic [DataWidth-1:0]   LastBin = '1;
   localparam logic [PixCntWidth-1:0] LastPix = PixCntWidth'(FramePixels - 1);

   heq_state_e             state_q, state_d;
   logic [DataWidth-1:0]   addr_d;
   logic                   rd_d, clr_d, done_d, busy_d, ovr_d;
   logic [PixCntWidth-1:0] pix_cnt_q, pix_cnt_d;
   logic                   scan_start;

   // Pixels are forwarded in ACCUM, and on the accepting frame-start cycle in IDLE.
   assign o_hist_inc_en = i_pixel_valid &
                          ((state_q == ACCUM) | ((state_q == IDLE) & i_frame_start));

   assign scan_start = (state_d == SCAN) & (state_q != SCAN);

   // Next state plus next values of the registered RAM/status outputs.
   always_comb begin
      state_d   = state_q;
      addr_d    = o_bin_addr;
      rd_d      = 1'b0;
      clr_d     = 1'b0;
      done_d    = 1'b0;
      pix_cnt_d = pix_cnt_q;

      case (state_q)
         INIT_CLR: begin
            // One lead cycle after reset, then the same sweep as CLEAR.
            if (!o_bin_clr) begin
               clr_d  = 1'b1;
               addr_d = '0;
            end else if (o_bin_addr == LastBin) begin
               state_d = IDLE;
               addr_d  = '0;
            end else begin
               clr_d  = 1'b1;
               addr_d = o_bin_addr + DataWidth'(1);
            end
         end
         IDLE: begin
            if (i_frame_start) begin
               state_d   = ACCUM;
               pix_cnt_d = '0;
            end
         end
         ACCUM: begin
         end
         SCAN: begin
            if (o_bin_addr == LastBin) begin
               state_d = CLEAR;
               clr_d   = 1'b1;
               addr_d  = '0;
            end else begin
               rd_d   = 1'b1;
               addr_d = o_bin_addr + DataWidth'(1);
            end
         end
         CLEAR: begin
            if (o_bin_addr == LastBin) begin
               state_d = DONE;
               done_d  = 1'b1;
               addr_d  = '0;
            end else begin
               clr_d  = 1'b1;
               addr_d = o_bin_addr + DataWidth'(1);
            end
         end
         DONE: begin
            state_d = IDLE;
         end
         default: begin
            state_d = INIT_CLR;
            addr_d  = '0;
         end
      endcase

      // Count forwarded pixels; the last one of the frame starts the scan next cycle.
      if (o_hist_inc_en) begin
         if (pix_cnt_q == LastPix) begin
            state_d   = SCAN;
            pix_cnt_d = '0;
            rd_d      = 1'b1;
            addr_d    = '0;
         end else begin
            pix_cnt_d = pix_cnt_q + PixCntWidth'(1);
         end
      end

      busy_d = (state_d != IDLE);
      ovr_d  = o_overrun | (i_pixel_valid & ~o_hist_inc_en);
   end

   // State, counters and registered outputs.
   always_ff @(posedge i_clk or negedge i_reset_n) begin
      if (!i_reset_n) begin
         state_q      <= INIT_CLR;
         pix_cnt_q    <= '0;
         o_bin_addr   <= '0;
         o_bin_rd     <= 1'b0;
         o_bin_clr    <= 1'b0;
         o_frame_done <= 1'b0;
         o_busy       <= 1'b0;
         o_overrun    <= 1'b0;
      end else begin
         state_q      <= state_d;
         pix_cnt_q    <= pix_cnt_d;
         o_bin_addr   <= addr_d;
         o_bin_rd     <= rd_d;
         o_bin_clr    <= clr_d;
         o_frame_done <= done_d;
         o_busy       <= busy_d;
         o_overrun    <= ovr_d;
      end
   end

`ifdef HEQ_FRAME_CTRL_FRAME_CNT_EN
   // Completed-frame counter, wraps naturally at 16 bits.
   always_ff @(posedge i_clk or negedge i_reset_n) begin
      if (!i_reset_n) begin
         o_frame_count <= '0;
      end else if (state_q == DONE) begin
         o_frame_count <= o_frame_count + 16'd1;
      end
   end
`else
`endif

   heq_cdf_accum #(
      .FramePixels (FramePixels),
      .PixCntWidth (PixCntWidth)
   ) u_cdf_accum (
      .i_clk        (i_clk),
      .i_reset_n    (i_reset_n),
      .i_scan_start (scan_start),
      .i_bin_rd     (o_bin_rd),
      .i_bin_data   (i_bin_data),
      .o_cdf_valid  (o_cdf_valid),
      .o_cdf        (o_cdf),
      .o_cdf_min    (o_cdf_min)
   );

endmodule
